reorder_trace_dispatcher: RTL and testbench

Initiator side of the reorder-logic trace protocol. Accepts whole instructions (ID plus a list of 1..MAX_UOPS queue selectors) over a valid/ready handshake. Serialises each instruction into per-cycle micro-op pushes toward `reorder_logic_top` and the per-queue execution queues. Marks the last micro-op with the breakpoint and the ID push, stalls on any full condition, and flags a stall deadlock.

---
 rtl/reorder_logic_pkg.sv | 41 ++++
 rtl/dispatch_stall_watchdog.sv | 48 ++++
 rtl/reorder_trace_dispatcher.sv | 154 +++++++++++++++
 tb/tb_reorder_trace_dispatcher.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_logic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reorder_logic_pkg                                                     |
// | Shared types and helpers for the reorder-logic trace dispatcher.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package reorder_logic_pkg;

   // Dispatcher FSM encoding
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   // Width of the zero-extended selector bus handed to sel_extract
   localparam int SEL_BUS_W = 256;

   // Normalise a micro-op count: 0 means 1, larger than max saturates
   function automatic int unsigned norm_count(input int unsigned cnt,
                                              input int unsigned max_uops);
      int unsigned r;
      r = cnt;
      if (cnt == 0) begin
         r = 1;
      end else if (cnt > max_uops) begin
         r = max_uops;
      end
      return r;
   endfunction

   // Extract selector slot idx (sel_w bits wide, at most 8) from a packed bus
   function automatic logic [7:0] sel_extract(input logic [SEL_BUS_W-1:0] bus,
                                              input int unsigned idx,
                                              input int unsigned sel_w);
      logic [SEL_BUS_W-1:0] sh;
      sh = bus >> (idx * sel_w);
      return sh[7:0] & 8'((1 << sel_w) - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_stall_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dispatch_stall_watchdog                                               |
// | Saturating consecutive-stall counter with a sticky deadlock flag.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module dispatch_stall_watchdog #(
   parameter  int MAX_STALL   = 2000,
   localparam int STALL_WIDTH = $clog2(MAX_STALL + 1)
) (
   input  logic clk_i,
   input  logic ars_i,
   input  logic stall_i,
   output logic deadlock_o
);

   logic [STALL_WIDTH-1:0] cnt_q, cnt_d;
   logic                   deadlock_q, deadlock_d;

   // Count stalled cycles, clear on anything else; flag is sticky once the limit is hit
   always_comb begin
      cnt_d      = cnt_q;
      deadlock_d = deadlock_q;
      if (!stall_i) begin
         cnt_d = '0;
      end else if (cnt_q != STALL_WIDTH'(MAX_STALL)) begin
         cnt_d = cnt_q + STALL_WIDTH'(1);
      end
      if (cnt_d == STALL_WIDTH'(MAX_STALL)) begin
         deadlock_d = 1'b1;
      end
   end

   // Counter and flag registers
   always_ff @(posedge clk_i or posedge ars_i) begin
      if (ars_i) begin
         cnt_q      <= '0;
         deadlock_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         deadlock_q <= deadlock_d;
      end
   end

   assign deadlock_o = deadlock_q;

endmodule
`default_nettype wire

// File: rtl/reorder_trace_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reorder_trace_dispatcher                                              |
// | Serialises whole instructions into per-cycle micro-op trace pushes.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module reorder_trace_dispatcher #(
   parameter  int   NUM_QUEUES = 8,
   parameter  int   DEPTH      = 64,
   parameter  logic BREAKPOINT = 1'b1,
   parameter  int   MAX_UOPS   = 8,
   parameter  int   MAX_STALL  = 2000,
   localparam int   ID_WIDTH   = $clog2(DEPTH),
   localparam int   CNT_WIDTH  = $clog2(MAX_UOPS + 1),
   localparam int   SEL_WIDTH  = $clog2(NUM_QUEUES)
) (
   input  logic                          clk_i,
   input  logic                          ars_i,
   input  logic                          instr_valid_i,
   output logic                          instr_ready_o,
   input  logic [ID_WIDTH-1:0]           instr_id_i,
   input  logic [CNT_WIDTH-1:0]          instr_count_i,
   input  logic [MAX_UOPS*SEL_WIDTH-1:0] instr_sels_i,
   input  logic                          full_i,
   input  logic [NUM_QUEUES-1:0]         queues_full_i,
   output logic                          trace_push_o,
   output logic [SEL_WIDTH-1:0]          trace_sel_o,
   output logic                          trace_break_o,
   output logic                          trace_id_push_o,
   output logic [ID_WIDTH-1:0]           trace_id_value_o,
   output logic [NUM_QUEUES-1:0]         queue_push_o,
   output logic                          busy_o,
   output logic                          deadlock_o,
   output logic [31:0]                   instr_cnt_o,
   output logic [31:0]                   uop_cnt_o
);
   import reorder_logic_pkg::*;

   state_t                        state_q, state_d;
   logic [ID_WIDTH-1:0]           id_q, id_d;
   logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]          k_q, k_d;
   logic [MAX_UOPS*SEL_WIDTH-1:0] sels_q, sels_d;
   logic [31:0]                   instr_cnt_q, instr_cnt_d;
   logic [31:0]                   uop_cnt_q, uop_cnt_d;

   logic [SEL_BUS_W-1:0]          sels_bus;
   logic [SEL_WIDTH-1:0]          cur_sel;
   logic                          can_push;
   logic                          is_last;
   logic                          load;
   logic                          stall;

   // Next-state, issue control and combinational push outputs
   always_comb begin
      state_d         = state_q;
      id_d            = id_q;
      cnt_d           = cnt_q;
      k_d             = k_q;
      sels_d          = sels_q;
      instr_cnt_d     = instr_cnt_q;
      uop_cnt_d       = uop_cnt_q;
      load            = 1'b0;
      instr_ready_o   = 1'b0;
      trace_push_o    = 1'b0;
      trace_sel_o     = '0;
      trace_break_o   = ~BREAKPOINT;
      trace_id_push_o = 1'b0;

      sels_bus = '0;
      sels_bus[MAX_UOPS*SEL_WIDTH-1:0] = sels_q;
      cur_sel  = SEL_WIDTH'(sel_extract(sels_bus, 32'(k_q), SEL_WIDTH));
      can_push = ~full_i & ~queues_full_i[cur_sel];
      is_last  = (k_q == cnt_q - CNT_WIDTH'(1));

      case (state_q)
         IDLE: begin
            instr_ready_o = 1'b1;
            if (instr_valid_i) begin
               load = 1'b1;
            end
         end
         ISSUE: begin
            if (can_push) begin
               trace_push_o = 1'b1;
               trace_sel_o  = cur_sel;
               uop_cnt_d    = uop_cnt_q + 32'd1;
               k_d          = k_q + CNT_WIDTH'(1);
               if (is_last) begin
                  trace_break_o   = BREAKPOINT;
                  trace_id_push_o = 1'b1;
                  instr_cnt_d     = instr_cnt_q + 32'd1;
                  instr_ready_o   = 1'b1;
                  if (instr_valid_i) begin
                     load = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A fresh accept overrides the index advance above
      if (load) begin
         state_d = ISSUE;
         id_d    = instr_id_i;
         cnt_d   = CNT_WIDTH'(norm_count(32'(instr_count_i), MAX_UOPS));
         sels_d  = instr_sels_i;
         k_d     = '0;
      end

      stall = (state_q == ISSUE) & ~can_push;
   end

   // State, latched instruction and counters
   always_ff @(posedge clk_i or posedge ars_i) begin
      if (ars_i) begin
         state_q     <= IDLE;
         id_q        <= '0;
         cnt_q       <= '0;
         k_q         <= '0;
         sels_q      <= '0;
         instr_cnt_q <= '0;
         uop_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         k_q         <= k_d;
         sels_q      <= sels_d;
         instr_cnt_q <= instr_cnt_d;
         uop_cnt_q   <= uop_cnt_d;
      end
   end

   dispatch_stall_watchdog #(
      .MAX_STALL (MAX_STALL)
   ) u_watchdog (
      .clk_i      (clk_i),
      .ars_i      (ars_i),
      .stall_i    (stall),
      .deadlock_o (deadlock_o)
   );

   assign queue_push_o     = trace_push_o ? (NUM_QUEUES'(1) << trace_sel_o) : '0;
   assign trace_id_value_o = (state_q == ISSUE) ? id_q : '0;
   assign busy_o           = (state_q == ISSUE);
   assign instr_cnt_o      = instr_cnt_q;
   assign uop_cnt_o        = uop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_reorder_trace_dispatcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reorder_trace_dispatcher                                           |
// | Randomised and directed bench with a transaction-level model.         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_reorder_trace_dispatcher;

   localparam logic BP     = 1'b1;
   localparam int   MAXS   = 10;

   logic        clk_i = 1'b0;
   logic        ars_i = 1'b1;
   logic        instr_valid_i = 1'b0;
   logic        instr_ready_o;
   logic [5:0]  instr_id_i = '0;
   logic [3:0]  instr_count_i = '0;
   logic [23:0] instr_sels_i = '0;
   logic        full_i = 1'b0;
   logic [7:0]  queues_full_i = '0;
   logic        trace_push_o;
   logic [2:0]  trace_sel_o;
   logic        trace_break_o;
   logic        trace_id_push_o;
   logic [5:0]  trace_id_value_o;
   logic [7:0]  queue_push_o;
   logic        busy_o;
   logic        deadlock_o;
   logic [31:0] instr_cnt_o;
   logic [31:0] uop_cnt_o;

   reorder_trace_dispatcher #(
      .NUM_QUEUES (8), .DEPTH (64), .BREAKPOINT (BP), .MAX_UOPS (8), .MAX_STALL (MAXS)
   ) dut (
      .clk_i (clk_i), .ars_i (ars_i),
      .instr_valid_i (instr_valid_i), .instr_ready_o (instr_ready_o),
      .instr_id_i (instr_id_i), .instr_count_i (instr_count_i), .instr_sels_i (instr_sels_i),
      .full_i (full_i), .queues_full_i (queues_full_i),
      .trace_push_o (trace_push_o), .trace_sel_o (trace_sel_o), .trace_break_o (trace_break_o),
      .trace_id_push_o (trace_id_push_o), .trace_id_value_o (trace_id_value_o),
      .queue_push_o (queue_push_o), .busy_o (busy_o), .deadlock_o (deadlock_o),
      .instr_cnt_o (instr_cnt_o), .uop_cnt_o (uop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Transaction-level model: the remaining micro-ops of the instruction in flight
   typedef struct {
      logic [2:0] sel;
      logic       last;
      logic [5:0] id;
   } uop_t;

   uop_t        exp_q[$];
   logic [31:0] m_uops = 0, m_instrs = 0;
   logic        m_dl = 0;
   int          run = 0;
   int          checks = 0, errors = 0;
   bit          mon_en = 0, acc_flag = 0, rand_stall = 0;
   int          cyc = 0, obs_push = 0;
   logic [2:0]  sel_log[$];
   logic [7:0]  qp_log[$];
   logic        brk_log[$];
   int          cyc_log[$];

   function automatic int nrm(input int c);
      return (c == 0) ? 1 : ((c > 8) ? 8 : c);
   endfunction

   // Random back-pressure while enabled
   always @(negedge clk_i) begin
      if (rand_stall) begin
         full_i = ($urandom_range(0, 5) == 0);
         for (int b = 0; b < 8; b++) queues_full_i[b] = ($urandom_range(0, 7) == 0);
      end
   end

   // Mid-cycle monitor: compares every output against the model
   always begin : mon
      logic stalled, exp_ready, exp_push, was_busy;
      logic [5:0] exp_idv;
      uop_t u;
      @(negedge clk_i);
      #3;
      cyc++;
      if (trace_push_o === 1'b1) obs_push++;
      if (mon_en) begin
         was_busy  = (exp_q.size() != 0);
         stalled   = was_busy && (full_i || queues_full_i[exp_q[0].sel]);
         exp_ready = !was_busy || (exp_q.size() == 1 && !stalled);
         exp_push  = was_busy && !stalled;
         exp_idv   = was_busy ? exp_q[0].id : 6'd0;
         checks += 7;
         if (busy_o !== was_busy) begin errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy_o, was_busy); end
         if (instr_ready_o !== exp_ready) begin errors++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, instr_ready_o, exp_ready); end
         if (uop_cnt_o !== m_uops) begin errors++; $display("FAIL uop_cnt cyc=%0d got=%0d exp=%0d", cyc, uop_cnt_o, m_uops); end
         if (instr_cnt_o !== m_instrs) begin errors++; $display("FAIL instr_cnt cyc=%0d got=%0d exp=%0d", cyc, instr_cnt_o, m_instrs); end
         if (deadlock_o !== m_dl) begin errors++; $display("FAIL deadlock cyc=%0d got=%b exp=%b", cyc, deadlock_o, m_dl); end
         if (trace_id_value_o !== exp_idv) begin errors++; $display("FAIL id_value cyc=%0d got=%0d exp=%0d", cyc, trace_id_value_o, exp_idv); end
         if (trace_push_o !== exp_push) begin errors++; $display("FAIL push cyc=%0d got=%b exp=%b", cyc, trace_push_o, exp_push); end
         checks += 4;
         if (exp_push) begin
            u = exp_q.pop_front();
            if (trace_sel_o !== u.sel) begin errors++; $display("FAIL sel cyc=%0d got=%0d exp=%0d", cyc, trace_sel_o, u.sel); end
            if (trace_break_o !== (u.last ? BP : ~BP)) begin errors++; $display("FAIL break cyc=%0d got=%b last=%b", cyc, trace_break_o, u.last); end
            if (trace_id_push_o !== u.last) begin errors++; $display("FAIL id_push cyc=%0d got=%b exp=%b", cyc, trace_id_push_o, u.last); end
            if (queue_push_o !== (8'd1 << u.sel)) begin errors++; $display("FAIL qpush cyc=%0d got=%h sel=%0d", cyc, queue_push_o, u.sel); end
            sel_log.push_back(trace_sel_o);
            qp_log.push_back(queue_push_o);
            brk_log.push_back(trace_break_o);
            cyc_log.push_back(cyc);
            m_uops++;
            if (u.last) m_instrs++;
         end else begin
            if (trace_sel_o !== 3'd0) begin errors++; $display("FAIL idle_sel cyc=%0d got=%0d exp=0", cyc, trace_sel_o); end
            if (trace_break_o !== ~BP) begin errors++; $display("FAIL idle_break cyc=%0d got=%b exp=%b", cyc, trace_break_o, ~BP); end
            if (trace_id_push_o !== 1'b0) begin errors++; $display("FAIL idle_id_push cyc=%0d got=%b exp=0", cyc, trace_id_push_o); end
            if (queue_push_o !== 8'd0) begin errors++; $display("FAIL idle_qpush cyc=%0d got=%h exp=0", cyc, queue_push_o); end
         end
         if (was_busy && stalled) begin
            if (run < MAXS) run++;
            if (run == MAXS) m_dl = 1'b1;
         end else begin
            run = 0;
         end
         acc_flag = instr_valid_i && exp_ready;
         if (acc_flag) begin
            for (int j = 0; j < nrm(int'(instr_count_i)); j++) begin
               u.sel  = instr_sels_i[j*3 +: 3];
               u.last = (j == nrm(int'(instr_count_i)) - 1);
               u.id   = instr_id_i;
               exp_q.push_back(u);
            end
         end
      end
   end

   task automatic clear_logs();
      sel_log.delete(); qp_log.delete(); brk_log.delete(); cyc_log.delete();
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      ars_i = 1'b1; mon_en = 0; instr_valid_i = 0; full_i = 0; queues_full_i = '0;
      exp_q.delete(); m_uops = 0; m_instrs = 0; m_dl = 0; run = 0;
      repeat (2) @(negedge clk_i);
      ars_i = 1'b0; mon_en = 1;
   endtask

   task automatic send(input logic [5:0] id, input logic [3:0] cnt, input logic [23:0] sels);
      bit ok = 0;
      @(negedge clk_i);
      instr_valid_i = 1; instr_id_i = id; instr_count_i = cnt; instr_sels_i = sels;
      for (int t = 0; t < 200; t++) begin
         #4;
         if (acc_flag) begin ok = 1; break; end
         @(negedge clk_i);
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL accept_timeout id=%0d got=not_accepted exp=accepted", id); end
      @(posedge clk_i); #1;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk_i); #4;
         if (exp_q.size() == 0) begin ok = 1; break; end
      end
      @(posedge clk_i); #1;
      checks += 2;
      if (!ok) begin errors++; $display("FAIL idle_timeout got=busy exp=idle"); end
      if (busy_o !== 1'b0) begin errors++; $display("FAIL busy_after got=%b exp=0", busy_o); end
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (instr_ready_o !== 1'b1 || trace_break_o !== ~BP || trace_push_o !== 1'b0 ||
          trace_sel_o !== 3'd0 || trace_id_push_o !== 1'b0 || trace_id_value_o !== 6'd0 ||
          queue_push_o !== 8'd0 || busy_o !== 1'b0 || deadlock_o !== 1'b0 ||
          instr_cnt_o !== 32'd0 || uop_cnt_o !== 32'd0) begin
         errors++;
         $display("FAIL %s got rdy=%b brk=%b push=%b sel=%0d idp=%b idv=%0d qp=%h busy=%b dl=%b ic=%0d uc=%0d exp rdy=1 brk=0 rest=0",
                  tag, instr_ready_o, trace_break_o, trace_push_o, trace_sel_o, trace_id_push_o,
                  trace_id_value_o, queue_push_o, busy_o, deadlock_o, instr_cnt_o, uop_cnt_o);
      end
   endtask

   task automatic test_reset();
      #1;
      check_reset_outputs("reset_during");
      @(negedge clk_i); #1;
      check_reset_outputs("reset_held");
      ars_i = 1'b0; mon_en = 1;
      @(negedge clk_i); #4;
      check_reset_outputs("reset_after");
   endtask

   task automatic test_single();
      int p0;
      clear_logs(); p0 = obs_push;
      send(6'd5, 4'd3, {3'd0, 3'd7, 3'd2});
      instr_valid_i = 0;
      wait_idle();
      checks += 4;
      if (obs_push - p0 != 3) begin errors++; $display("FAIL single_pushes got=%0d exp=3", obs_push - p0); end
      if (qp_log.size() != 3 || qp_log[0] !== 8'h04 || qp_log[1] !== 8'h80 || qp_log[2] !== 8'h01) begin
         errors++; $display("FAIL single_qpush got=%p exp=04,80,01", qp_log);
      end
      if (brk_log.size() != 3 || brk_log[0] !== ~BP || brk_log[1] !== ~BP || brk_log[2] !== BP) begin
         errors++; $display("FAIL single_break got=%p exp=0,0,1", brk_log);
      end
      if (cyc_log.size() != 3 || cyc_log[2] - cyc_log[0] != 2) begin errors++; $display("FAIL single_spacing got=%p exp=consecutive", cyc_log); end
   endtask

   task automatic test_count0();
      int p0;
      clear_logs(); p0 = obs_push;
      send(6'd9, 4'd0, 24'($urandom));
      instr_valid_i = 0;
      wait_idle();
      checks += 2;
      if (obs_push - p0 != 1) begin errors++; $display("FAIL count0_pushes got=%0d exp=1", obs_push - p0); end
      if (brk_log.size() != 1 || brk_log[0] !== BP) begin errors++; $display("FAIL count0_break got=%p exp=1", brk_log); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      clear_logs();
      send(6'd1, 4'd2, 24'($urandom));
      send(6'd2, 4'd1, 24'($urandom));
      instr_valid_i = 0;
      wait_idle();
      checks += 2;
      if (cyc_log.size() != 3 || cyc_log[2] - cyc_log[0] != 2) begin errors++; $display("FAIL b2b_cycles got=%p exp=3_consecutive", cyc_log); end
      if (instr_cnt_o !== 32'd2) begin errors++; $display("FAIL b2b_instr_cnt got=%0d exp=2", instr_cnt_o); end
   endtask

   task automatic test_stalls();
      clear_logs();
      send(6'd3, 4'd4, {12'd0, 3'd6, 3'd3, 3'd5, 3'd1});
      instr_valid_i = 0;
      @(negedge clk_i);
      @(negedge clk_i); full_i = 1;
      repeat (3) @(negedge clk_i);
      @(negedge clk_i); full_i = 0; queues_full_i = 8'h08;
      repeat (2) @(negedge clk_i);
      @(negedge clk_i); queues_full_i = '0;
      wait_idle();
      checks += 2;
      if (sel_log.size() != 4 || sel_log[0] !== 3'd1 || sel_log[1] !== 3'd5 || sel_log[2] !== 3'd3 || sel_log[3] !== 3'd6) begin
         errors++; $display("FAIL stall_sels got=%p exp=1,5,3,6", sel_log);
      end
      if (cyc_log.size() != 4 || cyc_log[3] - cyc_log[0] != 9) begin errors++; $display("FAIL stall_timing got=%p exp=span_9", cyc_log); end
   endtask

   task automatic test_deadlock();
      do_reset();
      send(6'd7, 4'd2, 24'($urandom));
      instr_valid_i = 0; full_i = 1;
      repeat (10) @(negedge clk_i); #4;
      checks++;
      if (deadlock_o !== 1'b0) begin errors++; $display("FAIL deadlock_early got=%b exp=0", deadlock_o); end
      @(negedge clk_i); #4;
      checks++;
      if (deadlock_o !== 1'b1) begin errors++; $display("FAIL deadlock_set got=%b exp=1", deadlock_o); end
      @(negedge clk_i); full_i = 0;
      wait_idle();
      checks += 2;
      if (deadlock_o !== 1'b1) begin errors++; $display("FAIL deadlock_sticky got=%b exp=1", deadlock_o); end
      if (instr_cnt_o !== 32'd1) begin errors++; $display("FAIL deadlock_complete got=%0d exp=1", instr_cnt_o); end
   endtask

   task automatic test_reset_mid();
      int p0;
      do_reset();
      send(6'd4, 4'd5, 24'($urandom));
      instr_valid_i = 0;
      repeat (2) @(negedge clk_i);
      @(posedge clk_i); #1;
      ars_i = 1; mon_en = 0;
      exp_q.delete(); m_uops = 0; m_instrs = 0; m_dl = 0; run = 0;
      #1;
      check_reset_outputs("reset_mid");
      repeat (2) @(negedge clk_i);
      ars_i = 0; mon_en = 1; p0 = obs_push;
      repeat (8) @(negedge clk_i);
      #4;
      checks += 2;
      if (obs_push != p0) begin errors++; $display("FAIL reset_mid_pushes got=%0d exp=0", obs_push - p0); end
      if (instr_ready_o !== 1'b1) begin errors++; $display("FAIL reset_mid_ready got=%b exp=1", instr_ready_o); end
   endtask

   task automatic test_random();
      int p0, total;
      p0 = obs_push; total = 0;
      rand_stall = 1;
      for (int n = 0; n < 40; n++) begin
         logic [3:0] c;
         c = 4'($urandom_range(0, 15));
         total += nrm(int'(c));
         send(6'($urandom), c, 24'($urandom));
         if ($urandom_range(0, 1) == 0) begin
            instr_valid_i = 0;
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
         end
      end
      instr_valid_i = 0;
      wait_idle();
      rand_stall = 0;
      @(negedge clk_i); full_i = 0; queues_full_i = '0;
      checks++;
      if (obs_push - p0 != total) begin errors++; $display("FAIL random_total got=%0d exp=%0d", obs_push - p0, total); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_count0();
      test_back_to_back();
      test_stalls();
      test_deadlock();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
